// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// Rotating-priority search: first asserted req at or after ptr, wrapping modulo NCH.
module rr_pick
    import mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    int idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 0; i < NCH; i++) begin
            // Wrap at NCH, not 2**SELW, so unused index codes are never visited.
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux with fixed-select or round-robin grant and a
// one-deep output register that can load on the same edge it drains.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      s,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_ch,
    output logic                 y_valid,
    input  logic                 y_ready
);

    localparam int              NPAD   = 1 << SELW;
    localparam logic [SELW:0]   NCH_W  = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH-1);

    logic [WIDTH-1:0] y_q, y_d;
    logic [SELW-1:0]  ych_q, ych_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             yv_q, yv_d;

    logic             load_en;
    logic             granted;
    logic [SELW-1:0]  gnt_idx;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [NPAD-1:0]  valid_pad;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Padding lets an out-of-range fixed select index safely; the range check rejects it.
    assign valid_pad = NPAD'(in_valid);
    assign load_en   = !yv_q || y_ready;

    always_comb begin
        gnt_idx = rr_idx;
        granted = rr_any;
        if (mode == MODE_FIXED) begin
            gnt_idx = s;
            granted = ({1'b0, s} < NCH_W) && valid_pad[s];
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == SELW'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Accept is suppressed during reset: a word taken then would be discarded.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            in_ready[k] = !rst && load_en && granted && (gnt_idx == SELW'(k));
        end
    end

    always_comb begin
        y_d   = y_q;
        ych_d = ych_q;
        yv_d  = yv_q;
        ptr_d = ptr_q;
        if (load_en) begin
            if (granted) begin
                y_d   = sel_data;
                ych_d = gnt_idx;
                yv_d  = 1'b1;
                if (mode == MODE_RR) begin
                    ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                yv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            ych_q <= '0;
            yv_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            ych_q <= ych_d;
            yv_q  <= yv_d;
            ptr_q <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = ych_q;
    assign y_valid = yv_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: a 4-channel and a 3-channel instance share stimulus
// and are compared every cycle against a queue-free behavioural model.
module tb_stream_mux_n;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  s;
    logic [31:0] data;
    logic [3:0]  valid;
    logic        yr;

    logic [3:0]  rdy4;
    logic [7:0]  y4;
    logic [1:0]  ych4;
    logic        yv4;
    logic [2:0]  rdy3;
    logic [7:0]  y3;
    logic [1:0]  ych3;
    logic        yv3;

    int checks = 0;
    int errors = 0;
    bit en_cmp = 0;

    // Model state, index 0 = NCH 4, index 1 = NCH 3
    int       m_ptr[2];
    logic [7:0] m_y[2];
    int       m_ych[2];
    bit       m_yv[2];

    stream_mux_n #(.WIDTH(8), .NCH(4)) u4 (
        .clk(clk), .rst(rst), .mode(mode), .s(s),
        .in_data(data), .in_valid(valid), .in_ready(rdy4),
        .y(y4), .y_ch(ych4), .y_valid(yv4), .y_ready(yr)
    );

    stream_mux_n #(.WIDTH(8), .NCH(3)) u3 (
        .clk(clk), .rst(rst), .mode(mode), .s(s),
        .in_data(data[23:0]), .in_valid(valid[2:0]), .in_ready(rdy3),
        .y(y3), .y_ch(ych3), .y_valid(yv3), .y_ready(yr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int nch_of(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [3:0] vmask(int d);
        return (d == 0) ? valid : {1'b0, valid[2:0]};
    endfunction

    function automatic bit pick(int nch, logic [3:0] v, bit md, int sv, int ptr, output int g);
        g = 0;
        if (!md) begin
            g = sv;
            return (sv < nch) && v[sv];
        end
        for (int i = 0; i < nch; i++) begin
            if (v[(ptr + i) % nch]) begin
                g = (ptr + i) % nch;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int g;
            bit any;
            if (rst) begin
                m_ptr[d] = 0; m_y[d] = 0; m_ych[d] = 0; m_yv[d] = 0;
            end else if (!m_yv[d] || yr) begin
                any = pick(nch_of(d), vmask(d), mode, int'(s), m_ptr[d], g);
                if (any) begin
                    m_y[d]   = data[g*8 +: 8];
                    m_ych[d] = g;
                    m_yv[d]  = 1;
                    if (mode) m_ptr[d] = (g + 1) % nch_of(d);
                end else begin
                    m_yv[d] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en_cmp) begin
            for (int d = 0; d < 2; d++) begin
                int g;
                bit any;
                logic [3:0] er;
                logic [3:0] ar;
                any = pick(nch_of(d), vmask(d), mode, int'(s), m_ptr[d], g);
                er = (!rst && (!m_yv[d] || yr) && any) ? 4'(1 << g) : 4'b0;
                ar = (d == 0) ? rdy4 : {1'b0, rdy3};
                chk(d == 0 ? "m4_in_ready" : "m3_in_ready", int'(ar), int'(er));
                chk(d == 0 ? "m4_y_valid" : "m3_y_valid", int'(d == 0 ? yv4 : yv3), int'(m_yv[d]));
                chk(d == 0 ? "m4_y_ch" : "m3_y_ch", int'(d == 0 ? ych4 : ych3), m_ych[d]);
                chk(d == 0 ? "m4_y" : "m3_y", int'(d == 0 ? y4 : y3), int'(m_y[d]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] held_y;
    logic [1:0] held_ch;

    initial begin
        rst = 1; mode = 0; s = 0; valid = 4'b1111; yr = 1;
        data = 32'h44332211;

        // Reset with all channels requesting
        tick();
        en_cmp = 1;
        chk("rst_in_ready", int'(rdy4), 0);
        tick();
        chk("rst_y", int'(y4), 0);
        chk("rst_y_ch", int'(ych4), 0);
        chk("rst_y_valid", int'(yv4), 0);
        chk("rst_in_ready2", int'(rdy4), 0);

        // Fixed select
        rst = 0; mode = 0; s = 2; valid = 4'b0100; data = 32'h00A50000;
        #1 chk("fix_in_ready", int'(rdy4), 4'b0100);
        tick();
        chk("fix_y", int'(y4), 8'hA5);
        chk("fix_y_ch", int'(ych4), 2);
        chk("fix_y_valid", int'(yv4), 1);
        s = 3;
        tick();
        chk("fix_drop_valid", int'(yv4), 0);
        chk("fix_hold_y", int'(y4), 8'hA5);

        // Round-robin fairness, pointer still at 0
        mode = 1; valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            data = $urandom;
            tick();
            chk("rr_seq_ch", int'(ych4), i % 4);
            chk("rr_seq_valid", int'(yv4), 1);
        end

        // Backpressure: hold for 5 cycles while inputs churn
        yr = 0;
        held_y = y4; held_ch = ych4;
        for (int i = 0; i < 5; i++) begin
            data = $urandom; valid = 4'($urandom_range(1, 15));
            #1 chk("bp_in_ready", int'(rdy4), 0);
            tick();
            chk("bp_hold_y", int'(y4), int'(held_y));
            chk("bp_hold_ch", int'(ych4), int'(held_ch));
        end
        yr = 1; valid = 4'b1111; data = 32'hDDCCBBAA;
        #1 chk("bp_release_ready", int'(rdy4), 4'b0100);
        tick();
        chk("bp_release_ch", int'(ych4), 2);
        chk("bp_release_y", int'(y4), 8'hCC);

        // Non-power-of-two channel count, starting from ptr 0
        rst = 1;
        tick();
        rst = 0; mode = 1; valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n3_rr_ch", int'(ych3), (i % 2) * 2);
        end
        mode = 0; s = 3; valid = 4'b1111;
        #1 chk("n3_fix_oob_ready", int'(rdy3), 0);
        tick();
        chk("n3_fix_oob_valid", int'(yv3), 0);

        // Reset while a word is stalled
        mode = 1; valid = 4'b1111; yr = 1;
        tick();
        yr = 0;
        tick();
        chk("mid_valid_before", int'(yv4), 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_valid_after", int'(yv4), 0);
        valid = 4'b1010; yr = 1;
        tick();
        chk("mid_first_rr_ch", int'(ych4), 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            s     = 2'($urandom);
            valid = 4'($urandom);
            data  = $urandom;
            yr    = ($urandom_range(0, 3) != 0);
            tick();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel, W-bit registered stream multiplexer: the next generation of the team's 8-bit 4:1 bus mux. It adds per-channel valid/ready handshakes, a one-deep output register, and two selection modes: fixed select, or round-robin arbitration. It sits between multiple producers (ALU results, register-file ports, I/O capture) and a single consumer bus.

## Interface
Parameters:
- WIDTH, 8, data width per channel
- NCH, 4, channel count (2..16, need not be a power of two)
- SELW, 2, select/channel-index width, = ceil(log2(NCH))

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = fixed select via s, 1 = round-robin
- s  in  SELW  channel select, fixed mode only
- in_data  in  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel data valid
- in_ready  out  NCH  per-channel accept (combinational)
- y  out  WIDTH  registered output data
- y_ch  out  SELW  source channel of y
- y_valid  out  1  output register holds a word
- y_ready  in  1  consumer accepts y

## Operation
- Internal signals:
  - load_en = !y_valid || y_ready
  - rr pointer ptr (SELW bits)
- Grant, combinational:
  - Fixed mode: grant s iff s < NCH and in_valid[s].
  - RR mode: first k with in_valid[k], searching ptr, ptr+1, … wrapping modulo NCH (not modulo 2^SELW).
- in_ready[k] = load_en && granted && grant == k. At most one in_ready bit is high; all are low when load_en = 0.
- On a clock edge with load_en and a grant (k):
  - y <= in_data[k]
  - y_ch <= k
  - y_valid <= 1
  - In RR mode only: ptr <= (k+1) mod NCH.
- On a clock edge with load_en and no grant: y_valid <= 0; y and y_ch hold.
- With y_valid && !y_ready: y, y_ch, and y_valid hold; ptr holds.
- The ptr is untouched in fixed mode. A switch to RR resumes from the last RR position.
- mode and s are sampled combinationally each cycle. A change affects the next grant only; a word already in the register is not affected.

## Timing
- Reset (rst high at an edge): y = 0, y_ch = 0, y_valid = 0, ptr = 0. Reset has priority over a simultaneous transfer. A held word is dropped.
- Latency: input accepted at edge n appears on y with y_valid from edge n (visible cycle n+1).
- Throughput: one word per cycle while y_ready is held high and a channel is eligible.
- Simultaneous y_ready and new grant in the same cycle: old word leaves and new word loads on the same edge, with no bubble.
- Wrap: NCH=3, ptr=2, channel 2 granted → ptr = 0.
- Combinational paths:
  - y_ready → in_ready
  - in_valid/mode/s → in_ready
- There is no combinational in→y path.

## Structure
- Shared package mux_pkg holds:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1
  - a ceil-log2 constant function for SELW derivation
- Sub-module rr_pick: combinational rotating priority search. Inputs are req[NCH] and ptr; outputs are gnt_idx and gnt_any. Reused by future arbiters.
- Top level holds only the output register, ptr register, and handshake logic.

## Test plan
- Reset: drive in_valid=4'b1111 with rst=1 for 2 cycles → y=0, y_ch=0, y_valid=0, in_ready=0 during reset.
- Fixed mode, NCH=4, W=8: s=2, in_data ch2=8'hA5, in_valid=4'b0100, y_ready=1 → in_ready=4'b0100, next cycle y=8'hA5, y_ch=2, y_valid=1. Then s=3 with in_valid[3]=0 → y_valid drops to 0 on the next edge.
- RR fairness: all four channels valid continuously, y_ready=1 → y_ch sequence 0,1,2,3,0,1… with one word per cycle.
- Backpressure: y_ready=0 with y_valid=1 for 5 cycles while inputs change → y, y_ch held, in_ready=0. Raising y_ready → a new word loads on the same edge.
- NCH=3 non-power-of-two: RR with in_valid=3'b101, starting ptr=0 → y_ch 0,2,0,2; ptr never reaches 3. Fixed mode with s=3 → no grant, in_ready=0.
- Reset mid-stream: assert rst while y_valid=1 and y_ready=0 → y_valid=0 next cycle, ptr=0, and the first post-reset RR grant goes to the lowest valid channel.
